fetch_packet_splitter: RTL
==========================

Name: fetch_packet_splitter

Overview:
- Sits directly downstream of the fetch-packet fifo and upstream of decode.
- Dequeues one multi-lane fetch packet through a ready/valid handshake and holds it.
- Issues the packet's valid instructions to decode one per cycle, lowest lane first, each with its computed PC.
- Supports back-to-back packets with no bubble and a synchronous flush for branch redirects.

Parameters:
INSTR_WIDTH, 32, width of one instruction lane
N_LANES, 2, instruction lanes per fetch packet (power of two, >=2)
PC_WIDTH, 32, PC width; lane i PC = base PC + 4*i
PKT_WIDTH, PC_WIDTH+N_LANES+N_LANES*INSTR_WIDTH, localparam, packed packet width

Ports:
clk  input  1  clock
rst_aL  input  1  asynchronous active-low reset
flush  input  1  synchronous flush: discard held packet
in_ready  output  1  drives the fifo's deq_ready
in_valid  input  1  from the fifo's deq_valid
in_data  input  PKT_WIDTH  packet: lane i at [i*INSTR_WIDTH +: INSTR_WIDTH]; lane mask at [N_LANES*INSTR_WIDTH +: N_LANES]; base PC in the top PC_WIDTH bits
out_ready  input  1  decode can accept
out_valid  output  1  instruction valid to decode
out_instr  output  INSTR_WIDTH  issued instruction
out_pc  output  PC_WIDTH  issued instruction PC
out_last  output  1  issued lane is the last remaining lane of its packet
stall_cycles  output  16  performance counter (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_aL.
- State registers:
  - pkt_valid
  - pkt_lanes (N_LANES*INSTR_WIDTH bits)
  - pkt_rem, the remaining-lane mask (N_LANES bits)
  - pkt_pc (PC_WIDTH bits)
- States:
  - EMPTY: pkt_valid=0.
  - HOLD: pkt_valid=1, pkt_rem!=0. The invariant is that pkt_rem is never 0 in HOLD.
- Reset (asynchronous assert, any time including mid-packet):
  - pkt_valid=0, pkt_rem=0, pkt_lanes=0, pkt_pc=0, stall_cycles=0.
  - Outputs: out_valid=0, in_ready=1, out_instr=0, out_pc=0, out_last=0.
- Combinational outputs:
  - sel = index of the lowest set bit of pkt_rem.
  - out_valid = pkt_valid & ~flush.
  - out_instr = pkt_lanes lane sel.
  - out_pc = pkt_pc + (sel<<2), truncated to PC_WIDTH (wraps).
  - out_last = pkt_rem has exactly one bit set.
  - in_ready = ~flush & (~pkt_valid | (out_ready & out_last)).
  - in_ready depends combinationally on out_ready. Decode must not make out_ready depend on in_ready.
- Transfers:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Next state, in priority order:
  1. flush: go to EMPTY. Nothing is accepted or issued that cycle, even if in_valid=1.
  2. in_fire with mask==0: packet consumed and dropped; go to EMPTY. This is only possible from EMPTY or on the last-lane fire.
  3. in_fire with mask!=0: load lanes, pkt_rem=mask, pkt_pc=base; go to HOLD.
     - If the same cycle also fires the old packet's last lane, that lane issues and the new packet replaces it.
     - Result: zero bubble, one instruction per cycle sustained.
  4. out_fire, not last: clear bit sel in pkt_rem; stay in HOLD.
  5. out_fire, last, no in_fire: go to EMPTY.
  6. Otherwise: hold all state.
- Latency: 1 cycle from packet handshake to first out_valid. Non-contiguous masks (e.g. 0b101) skip the cleared lanes with no idle cycles.
- Packet data is held stable while out_valid=1 & ~out_ready.

Optional Feature:
- Macro: FETCH_SPLIT_PERF_EN.
- Defined: stall_cycles increments each cycle with out_valid & ~out_ready. It saturates at 16'hFFFF and clears on reset only; flush does not clear it.
- Undefined: stall_cycles is tied to 0 and no counter flops are generated. Splitter behaviour is otherwise identical.

Test Plan:
- Reset then idle, in_valid=0 -> out_valid=0, in_ready=1, stall_cycles=0.
- Packet PC=0x1000, mask=0b11, lanes A/B, out_ready=1 -> cycle+1: A @0x1000, out_last=0, in_ready=0; cycle+2: B @0x1004, out_last=1, in_ready=1.
- Two packets (PC 0x2000 mask 0b11, PC 0x3000 mask 0b01) fed continuously -> output 0x2000, 0x2004, 0x3000 on three consecutive cycles, no bubble.
- Packet mask=0b00 -> accepted (in_ready=1), out_valid stays 0. Mask=0b10 at PC 0x4000 -> single issue @0x4004 with out_last=1.
- Packet held with out_ready=0 for 5 cycles then flush=1 -> out_instr stable during the stall, out_valid=0 after flush, next packet accepted. With FETCH_SPLIT_PERF_EN, stall_cycles=5.
- rst_aL pulsed low mid-packet (one lane issued) -> out_valid drops immediately (asynchronous), remaining lane never issues.

Source files
------------

// File: rtl/fetch_packet_splitter_if.sv
// fetch_packet_splitter_if
//   Bundles the splitter's handshake and data signals.
//   Fifo side: in_valid/in_data come in, and in_ready goes back out.
//   Decode side: out_valid, out_instr, out_pc and out_last go out, and out_ready comes back.
//   Also carries flush (branch redirect) and the stall_cycles perf counter.
//   Modports:
//     slave  : the splitter
//     master : the environment, which plays both the fifo and decode
interface fetch_packet_splitter_if #(
  parameter int INSTR_WIDTH = 32,
  parameter int N_LANES     = 2,
  parameter int PC_WIDTH    = 32
);
  localparam int PKT_WIDTH = PC_WIDTH + N_LANES + N_LANES*INSTR_WIDTH;

  logic                   flush;
  logic                   in_ready;
  logic                   in_valid;
  logic [PKT_WIDTH-1:0]   in_data;
  logic                   out_ready;
  logic                   out_valid;
  logic [INSTR_WIDTH-1:0] out_instr;
  logic [PC_WIDTH-1:0]    out_pc;
  logic                   out_last;
  logic [15:0]            stall_cycles;

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_last, stall_cycles
  );

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_last, stall_cycles
  );
endinterface

// File: rtl/fetch_packet_splitter.sv
// fetch_packet_splitter
//   Takes one multi-lane fetch packet from the fetch fifo and holds it.
//   Issues the packet's valid lanes to decode one per cycle, lowest lane
//   first, each with PC = base + 4*lane.
//   A new packet may load in the same cycle that the old packet's last lane
//   issues, so a continuous stream runs with no bubble.
//   flush drops the held packet synchronously.
//   Ports:
//     clk, rst_aL : clock, asynchronous active-low reset
//     bus (slave) : flush, in_* (fifo side), out_* (decode side), stall_cycles
//   Optional macro FETCH_SPLIT_PERF_EN:
//     When defined, stall_cycles is a saturating count of cycles with
//     out_valid & ~out_ready.
//     When undefined, stall_cycles is tied to 0.
module fetch_packet_splitter #(
  parameter int INSTR_WIDTH = 32,
  parameter int N_LANES     = 2,
  parameter int PC_WIDTH    = 32
) (
  input  logic                          clk,
  input  logic                          rst_aL,
  fetch_packet_splitter_if.slave        bus
);
  localparam int PKT_WIDTH = PC_WIDTH + N_LANES + N_LANES*INSTR_WIDTH;
  localparam int SEL_W     = $clog2(N_LANES);

  typedef enum logic {EMPTY = 1'b0, HOLD = 1'b1} state_e;

  state_e                                state_q, state_d;
  logic [N_LANES-1:0][INSTR_WIDTH-1:0]   pkt_lanes_q, pkt_lanes_d;
  logic [N_LANES-1:0]                    pkt_rem_q, pkt_rem_d;
  logic [PC_WIDTH-1:0]                   pkt_pc_q, pkt_pc_d;

  // Unpack the incoming packet into lanes, lane mask and base PC.
  logic [N_LANES-1:0][INSTR_WIDTH-1:0]   in_lanes;
  logic [N_LANES-1:0]                    in_mask;
  logic [PC_WIDTH-1:0]                   in_pc;
  assign in_lanes = bus.in_data[N_LANES*INSTR_WIDTH-1:0];
  assign in_mask  = bus.in_data[N_LANES*INSTR_WIDTH +: N_LANES];
  assign in_pc    = bus.in_data[PKT_WIDTH-1 -: PC_WIDTH];

  logic             pkt_valid;
  logic [SEL_W-1:0] sel;
  logic             last;
  logic             in_fire, out_fire;

  assign pkt_valid = (state_q == HOLD);

  // Priority encoder: find the lowest remaining lane.
  always_comb begin
    sel = '0;
    for (int i = N_LANES-1; i >= 0; i--)
      if (pkt_rem_q[i]) sel = SEL_W'(i);
  end

  // last is true when exactly one remaining bit is set.
  // rem & (rem-1) also gives the mask with the sel bit cleared.
  assign last = (pkt_rem_q != '0) && ((pkt_rem_q & (pkt_rem_q - 1'b1)) == '0);

  assign bus.out_valid = pkt_valid & ~bus.flush;
  assign bus.out_instr = pkt_lanes_q[sel];
  assign bus.out_pc    = pkt_pc_q + (PC_WIDTH'(sel) << 2);
  assign bus.out_last  = last;
  assign bus.in_ready  = ~bus.flush & (~pkt_valid | (bus.out_ready & last));

  assign in_fire  = bus.in_valid & bus.in_ready;
  assign out_fire = bus.out_valid & bus.out_ready;

  always_comb begin
    state_d     = state_q;
    pkt_lanes_d = pkt_lanes_q;
    pkt_rem_d   = pkt_rem_q;
    pkt_pc_d    = pkt_pc_q;
    if (bus.flush) begin
      state_d   = EMPTY;
      pkt_rem_d = '0;
    end else if (in_fire) begin
      // in_ready already requires the old packet to be gone or issuing
      // its last lane, so replacing the packet here loses nothing.
      if (in_mask == '0) begin
        state_d   = EMPTY;
        pkt_rem_d = '0;
      end else begin
        state_d     = HOLD;
        pkt_lanes_d = in_lanes;
        pkt_rem_d   = in_mask;
        pkt_pc_d    = in_pc;
      end
    end else if (out_fire) begin
      if (last) begin
        state_d   = EMPTY;
        pkt_rem_d = '0;
      end else begin
        pkt_rem_d = pkt_rem_q & (pkt_rem_q - 1'b1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      state_q     <= EMPTY;
      pkt_lanes_q <= '0;
      pkt_rem_q   <= '0;
      pkt_pc_q    <= '0;
    end else begin
      state_q     <= state_d;
      pkt_lanes_q <= pkt_lanes_d;
      pkt_rem_q   <= pkt_rem_d;
      pkt_pc_q    <= pkt_pc_d;
    end
  end

`ifdef FETCH_SPLIT_PERF_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (bus.out_valid && !bus.out_ready && stall_q != 16'hFFFF)
      stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) stall_q <= '0;
    else         stall_q <= stall_d;
  end

  assign bus.stall_cycles = stall_q;
`else
  assign bus.stall_cycles = '0;
`endif

endmodule
